reg_dump: RTL and testbench

Sequential read-out engine for the register file: on a start request it walks a contiguous, wrap-around range of register addresses through the register file's combinational read port and streams each `{address, data}` pair out over a valid/ready interface. It sits beside the register file as the reader counterpart to the datapath's write port, and feeds the debug/trace path that carries register contents off-chip or into the testbench scoreboard.

---
 rtl/reg_dump.sv | 125 ++++++++++++
 tb/tb_reg_dump.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// Register-file read-out engine: walks a wrap-around address range through the
// combinational read port and streams {address, data} pairs over valid/ready.
//
// state | meaning
// IDLE  | waiting for Start; Raddr holds the last address
// LOAD  | Raddr stable, capture RdData into the output word at the edge
// SEND  | word presented, waiting for OutReady
// DONE  | one-cycle Done pulse, then back to IDLE
module reg_dump #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic         Abort,
    input  logic [D-1:0] StartAddr,
    input  logic [D-1:0] EndAddr,
    output logic [D-1:0] Raddr,
    input  logic [W-1:0] RdData,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [D-1:0] OutAddr,
    output logic [W-1:0] OutData,
    output logic         Busy,
    output logic         Done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [D-1:0]   cur_q, cur_d;
    logic [D-1:0]   end_q, end_d;
    logic           valid_q, valid_d;
    logic [D-1:0]   addr_q, addr_d;
    logic [W-1:0]   data_q, data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            end_q   <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        end_d   = end_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    cur_d   = StartAddr;
                    end_d   = EndAddr;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (Abort) begin
                    state_d = S_IDLE;
                end else begin
                    data_d  = RdData;
                    addr_d  = cur_q;
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // A handshake coinciding with Abort still counts as delivered.
                if (Abort) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (OutReady) begin
                    valid_d = 1'b0;
                    if (cur_q == end_q) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = cur_q + D'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_LOAD) || (state_d == S_SEND);
        done_d = (state_d == S_DONE);
    end

    assign Raddr    = cur_q;
    assign OutValid = valid_q;
    assign OutAddr  = addr_q;
    assign OutData  = data_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// Randomized scoreboard bench for reg_dump with a behavioural register file.
module tb_reg_dump;
    localparam int W = 8;
    localparam int D = 3;
    localparam int N_REG = 1 << D;

    logic         Clk = 1'b0;
    logic         Reset_n, Start, Abort, OutReady;
    logic         OutValid, Busy, Done;
    logic [D-1:0] StartAddr, EndAddr, Raddr, OutAddr;
    logic [W-1:0] RdData, OutData;

    logic [W-1:0] mem [N_REG];
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;

    logic [W-1:0]   model_mem [N_REG];
    logic [D+W-1:0] exp_q [$];
    int             done_q [$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_count = 0;
    int ready_pct = 100;

    reg_dump #(.W(W), .D(D)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Abort(Abort),
        .StartAddr(StartAddr), .EndAddr(EndAddr), .Raddr(Raddr), .RdData(RdData),
        .OutValid(OutValid), .OutReady(OutReady), .OutAddr(OutAddr), .OutData(OutData),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;
    always @(posedge Clk) if (wr_en) mem[wr_addr] <= wr_data;
    assign RdData = mem[Raddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Consumer readiness, redrawn every cycle.
    initial begin
        OutReady = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            OutReady = (int'($urandom_range(0, 99)) < ready_pct);
        end
    end

    // Monitor: pops the scoreboard on every handshake and Done pulse.
    logic         pv = 1'b0, pr = 1'b0, pab = 1'b0;
    logic [D-1:0] pa = '0;
    logic [W-1:0] pd = '0;
    always @(negedge Clk) begin
        logic [D+W-1:0] e;
        int t;
        if (Reset_n) begin
            if (pv && !pr && !pab) begin
                check("hold_valid", OutValid, 1);
                check("hold_addr", OutAddr, pa);
                check("hold_data", OutData, pd);
            end
            if (OutValid && OutReady) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got addr %0d data %0h, none expected", OutAddr, OutData);
                end else begin
                    e = exp_q.pop_front();
                    check("word_addr", OutAddr, e[D+W-1:W]);
                    check("word_data", OutData, e[W-1:0]);
                end
            end
            if (Done) begin
                if (done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got Done=1 at edge %0d, none expected", cyc);
                end else begin
                    t = done_q.pop_front();
                    if (t >= 0) check("done_edge", cyc, t);
                end
            end
        end
        pv  = OutValid;
        pr  = OutReady;
        pa  = OutAddr;
        pd  = OutData;
        pab = Abort;
    end

    task automatic write_reg(input int a, input logic [W-1:0] v);
        wr_en = 1'b1;
        wr_addr = a[D-1:0];
        wr_data = v;
        model_mem[a] = v;
        tick();
        wr_en = 1'b0;
    endtask

    // nw < 0 expects the whole range; done_mode 0=none, 1=any time, 2=exact edge.
    task automatic start_dump(input int s, input int e, input int nw, input int done_mode);
        int k, n, a;
        logic [D-1:0] ab;
        k = ((e - s + N_REG) % N_REG) + 1;
        n = (nw < 0) ? k : nw;
        for (int i = 0; i < n; i++) begin
            a = (s + i) % N_REG;
            ab = a[D-1:0];
            exp_q.push_back({ab, model_mem[a]});
        end
        Start = 1'b1;
        StartAddr = s[D-1:0];
        EndAddr = e[D-1:0];
        tick();
        Start = 1'b0;
        if (done_mode == 2) done_q.push_back(cyc + 2 * k);
        else if (done_mode == 1) done_q.push_back(-1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || Busy || Done) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d words and %0d dones pending, expected 0", name, exp_q.size(), done_q.size());
            exp_q.delete();
            done_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, e, base, n;
        Reset_n = 1'b0;
        Start = 1'b0;
        Abort = 1'b0;
        StartAddr = '0;
        EndAddr = '0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < N_REG; i++) write_reg(i, 8'h10 + W'(i));
        check("rst_raddr", Raddr, 0);
        check("rst_valid", OutValid, 0);
        check("rst_addr", OutAddr, 0);
        check("rst_data", OutData, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        Reset_n = 1'b1;
        tick();

        start_dump(0, 7, -1, 2);
        wait_idle("full");
        start_dump(6, 1, -1, 2);
        wait_idle("wrap");
        start_dump(3, 3, -1, 2);
        wait_idle("single");

        // Write landing on the LOAD edge must not be seen.
        start_dump(4, 4, -1, 2);
        wr_en = 1'b1;
        wr_addr = 3'd4;
        wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        model_mem[4] = 8'hAA;
        wait_idle("same_cycle_write");
        // Write one cycle before the LOAD edge must be seen.
        write_reg(4, 8'h14);
        wr_en = 1'b1;
        wr_addr = 3'd4;
        wr_data = 8'hAA;
        model_mem[4] = 8'hAA;
        start_dump(4, 4, -1, 2);
        wr_en = 1'b0;
        wait_idle("early_write");

        ready_pct = 30;
        for (int r = 0; r < 12; r++) begin
            for (int w = 0; w < 3; w++) write_reg($urandom_range(0, N_REG - 1), W'($urandom));
            start_dump($urandom_range(0, N_REG - 1), $urandom_range(0, N_REG - 1), -1, 1);
            wait_idle("backpressure");
        end
        ready_pct = 100;
        tick();
        for (int r = 0; r < 6; r++) begin
            start_dump($urandom_range(0, N_REG - 1), $urandom_range(0, N_REG - 1), -1, 2);
            wait_idle("random_full_rate");
        end

        // Abort during SEND of the third word; a Start mid-dump is ignored.
        base = hs_count;
        start_dump(0, 7, 2, 0);
        Start = 1'b1;
        StartAddr = 3'd5;
        EndAddr = 3'd5;
        tick();
        Start = 1'b0;
        n = 0;
        while (hs_count - base < 2 && n < 50) begin tick(); n++; end
        ready_pct = 0;
        while (!(OutValid && hs_count - base == 2) && n < 50) begin tick(); n++; end
        check("abort_reached_third", n < 50, 1);
        check("abort_third_addr", OutAddr, 2);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("abort_valid", OutValid, 0);
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_words", hs_count - base, 2);
        repeat (6) tick();
        check("abort_stays_idle", Busy, 0);
        exp_q.delete();

        // Asynchronous reset mid-SEND.
        tick();
        start_dump(2, 6, -1, 0);
        n = 0;
        while (!OutValid && n < 20) begin tick(); n++; end
        check("pre_reset_valid", OutValid, 1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_raddr", Raddr, 0);
        check("async_valid", OutValid, 0);
        check("async_addr", OutAddr, 0);
        check("async_data", OutData, 0);
        check("async_busy", Busy, 0);
        check("async_done", Done, 0);
        exp_q.delete();
        done_q.delete();
        tick();
        Reset_n = 1'b1;
        ready_pct = 100;
        tick();
        start_dump(5, 2, -1, 2);
        wait_idle("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
